instruction_fetch_unit: RTL and testbench

//   Fetch sequencer for the word-addressed, combinational-read instruction memory.

---
 rtl/instruction_fetch_unit.sv | 85 ++++++++
 tb/tb_instruction_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: owns the PC, reads the combinational instruction memory and
// buffers fetched words in a 2-entry FIFO that feeds decode over valid/ready.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] Mem_Address,
    input  logic [31:0] Mem_Instruction,
    output logic        IF_Valid,
    input  logic        IF_Ready,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Halted
);

    typedef enum logic {
        FETCH,
        HALT
    } state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        head;
    logic [1:0]  count;

    logic        in_range;
    logic        pop;
    logic        push;
    logic        tail;

    assign in_range = ({2'b00, pc[31:2]} < MEM_LIMIT);
    assign pop      = IF_Valid & IF_Ready;
    assign push     = (state == FETCH) & in_range & ((count < 2'd2) | pop) & ~Redirect;
    // With two slots the tail is the head when the FIFO is empty or full.
    assign tail     = head ^ count[0];

    assign Mem_Address    = {pc[31:2], 2'b00};
    assign IF_Valid       = (count != 2'd0);
    assign IF_Instruction = IF_Valid ? fifo_instr[head] : 32'h0;
    assign IF_PC          = IF_Valid ? fifo_pc[head]    : 32'h0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc     <= RESET_PC & ~32'h3;
            count  <= 2'd0;
            head   <= 1'b0;
            state  <= FETCH;
            Halted <= 1'b0;
        end else if (Redirect) begin
            // A pop in this cycle is simply swallowed by the flush.
            pc     <= RedirectPC & ~32'h3;
            count  <= 2'd0;
            head   <= 1'b0;
            state  <= FETCH;
            Halted <= 1'b0;
        end else begin
            if (push) begin
                fifo_instr[tail] <= Mem_Instruction;
                fifo_pc[tail]    <= {pc[31:2], 2'b00};
                pc               <= pc + 32'd4;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (state == FETCH && !in_range) begin
                state  <= HALT;
                Halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a queue of expected PCs is
// filled as fetch streams are set up and drained as decode accepts words.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_Instruction;
    logic        IF_Valid;
    logic        IF_Ready = 1'b0;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        Halted;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expQ[$];

    always #5 Clk = ~Clk;

    // Memory contents are tagged so an instruction is never equal to its address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00} ^ 32'hCAFE_0000;
    endfunction

    assign Mem_Instruction = memWord(Mem_Address);

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(14)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Mem_Address    (Mem_Address),
        .Mem_Instruction(Mem_Instruction),
        .IF_Valid       (IF_Valid),
        .IF_Ready       (IF_Ready),
        .IF_Instruction (IF_Instruction),
        .IF_PC          (IF_PC),
        .Redirect       (Redirect),
        .RedirectPC     (RedirectPC),
        .Halted         (Halted)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ready, input logic redir,
                                 input logic [31:0] target);
        Rst        = rst;
        IF_Ready   = ready;
        Redirect   = redir;
        RedirectPC = target;
    endtask

    task automatic expectStream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back(start + 32'(4 * i));
        end
    endtask

    // Pops and compares each accepted word until the queue empties or the budget runs out.
    task automatic drain(input string tag, input bit randomReady);
        int          cycles;
        logic [31:0] e;
        cycles = 0;
        while (expQ.size() > 0 && cycles < 200) begin
            if (randomReady) IF_Ready = 1'($urandom_range(0, 1));
            if (IF_Valid && IF_Ready) begin
                e = expQ.pop_front();
                checkOutput({tag, " pc"}, IF_PC, e);
                checkOutput({tag, " instr"}, IF_Instruction, memWord(e));
            end
            tick();
            cycles++;
        end
        if (expQ.size() > 0) begin
            checkOutput({tag, " timeout"}, 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
    endtask

    initial begin
        $display("[TB] start");

        // Reset state, then first word one cycle after release.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst valid", {31'h0, IF_Valid}, 32'd0);
        checkOutput("rst instr", IF_Instruction, 32'h0);
        checkOutput("rst pc", IF_PC, 32'h0);
        checkOutput("rst halted", {31'h0, Halted}, 32'd0);
        checkOutput("rst addr", Mem_Address, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("cycle1 valid", {31'h0, IF_Valid}, 32'd1);
        expectStream(32'h0, 6);
        drain("stream", 1'b0);

        // Backpressure: FIFO saturates and the PC stalls at word 2.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        IF_Ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("stall addr", Mem_Address, 32'h8);
        checkOutput("stall head", IF_PC, 32'h0);
        IF_Ready = 1'b1;
        expectStream(32'h0, 8);
        drain("release", 1'b0);

        // Run off the end of the 14-word image.
        expectStream(32'h20, 6);
        drain("tail", 1'b0);
        tick();
        tick();
        checkOutput("halt halted", {31'h0, Halted}, 32'd1);
        checkOutput("halt valid", {31'h0, IF_Valid}, 32'd0);
        checkOutput("halt addr", Mem_Address, 32'h38);
        checkOutput("halt pc", IF_PC, 32'h0);

        // Redirect out of HALT back to zero, then drain with random ready.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("resume halted", {31'h0, Halted}, 32'd0);
        checkOutput("resume addr", Mem_Address, 32'h0);
        tick();
        checkOutput("resume valid", {31'h0, IF_Valid}, 32'd1);
        expectStream(32'h0, 6);
        drain("random", 1'b1);

        // Redirect while full drops both buffered words.
        IF_Ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("full valid", {31'h0, IF_Valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h13);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush valid", {31'h0, IF_Valid}, 32'd0);
        checkOutput("flush addr", Mem_Address, 32'h10);
        tick();
        checkOutput("redir valid", {31'h0, IF_Valid}, 32'd1);
        expectStream(32'h10, 3);
        drain("redir", 1'b0);

        // Redirect to an out-of-range target halts one cycle later.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_1000);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("oor halted0", {31'h0, Halted}, 32'd0);
        checkOutput("oor addr", Mem_Address, 32'h0000_1000);
        tick();
        checkOutput("oor halted1", {31'h0, Halted}, 32'd1);
        checkOutput("oor valid", {31'h0, IF_Valid}, 32'd0);

        // Reset mid-stream with a full FIFO.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("prerst valid", {31'h0, IF_Valid}, 32'd1);
        checkOutput("prerst addr", Mem_Address, 32'h10);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        checkOutput("midrst valid", {31'h0, IF_Valid}, 32'd0);
        checkOutput("midrst addr", Mem_Address, 32'h0);
        checkOutput("midrst halted", {31'h0, Halted}, 32'd0);
        tick();
        checkOutput("postrst pc", IF_PC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
